// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg
// Shared types and helpers for the cpu_run_ctrl slice.
//   run_state_t : run controller FSM state (IDLE, RST, RUN)
//   sat_inc     : saturating increment on a 64-bit container; callers
//                 zero-extend their counter and limit, then truncate back.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2
  } run_state_t;

  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] lim);
    return (val >= lim) ? lim : val + 64'd1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_halt_detect.sv
// halt_detect
// Watches the core PC while a run is active and flags program completion
// once the PC has sat on halt_pc for HALT_STABLE consecutive cycles.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   en           : high while the controller is in RUN; low clears the count
//   cpu_pc       : current PC from the core
//   halt_pc      : PC value of the program's final self-loop
//   halted       : combinational, high in the cycle the count reaches
//                  HALT_STABLE
module halt_detect
  import cpu_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [PC_W-1:0] cpu_pc,
  input  logic [PC_W-1:0] halt_pc,
  output logic            halted
);

  localparam int SW = $clog2(HALT_STABLE + 1);
  localparam logic [SW-1:0] STAB_LIM = SW'(HALT_STABLE);

  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_d;

  // halted looks at the value the counter is about to take, so a PC that
  // first matches in cycle n ends the run in cycle n+HALT_STABLE-1.
  always_comb begin
    stab_d = '0;
    if (en && (cpu_pc == halt_pc)) begin
      stab_d = SW'(sat_inc(64'(stab_q), 64'(STAB_LIM)));
    end
    halted = en && (stab_d == STAB_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run controller for the mips core: holds the core in reset for RST_CYCLES,
// releases it, detects completion by a stable halt PC, bounds each run by
// cfg_max_cycles and repeats the program NUM_RUNS times, flagging any run
// whose cycle count differs from run 0.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start           : one-cycle run request, honoured only in IDLE
//   abort           : abandon the sequence (wins over start and run end)
//   cfg_max_cycles  : per-run cycle budget, 0 = unlimited
//   halt_pc, cpu_pc : halt address and live core PC
//   core_reset      : registered active-high reset to the core
//   busy            : high in RST and RUN
//   done            : one-cycle pulse after the final run ends
//   timeout         : sticky, some run hit the budget
//   mismatch        : sticky, a run's count differed from run 0
//   cycles          : cycle count of the most recent completed run
//   run_idx         : index of the current/last run
//   state_dbg       : current FSM state, for observation only
//
// Handshake: start is a level sampled on each rising edge; it is acted on
// only when the FSM is in IDLE and abort is low, otherwise it is dropped.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES  = 2,
  parameter int NUM_RUNS    = 1,
  parameter int HALT_STABLE = 4,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [CNT_W-1:0]                cfg_max_cycles,
  input  logic [PC_W-1:0]                 halt_pc,
  input  logic [PC_W-1:0]                 cpu_pc,
  output logic                            core_reset,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic                            mismatch,
  output logic [CNT_W-1:0]                cycles,
  output logic [$clog2(NUM_RUNS+1)-1:0]   run_idx,
  output run_state_t                      state_dbg
);

  localparam int IDX_W = $clog2(NUM_RUNS + 1);
  localparam int RW    = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  run_state_t       state_q;
  run_state_t       state_d;
  logic [RW-1:0]    rst_cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] run_cnt_inc;
  logic [CNT_W-1:0] ref_q;
  logic             halted;
  logic             tmo_hit;
  logic             run_end;

  halt_detect #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt_detect (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == RUN),
    .cpu_pc  (cpu_pc),
    .halt_pc (halt_pc),
    .halted  (halted)
  );

  assign state_dbg = state_q;

  // Next-state logic. abort beats every other event in RST and RUN.
  always_comb begin
    state_d     = state_q;
    run_cnt_inc = CNT_W'(sat_inc(64'(run_cnt_q), 64'(CNT_MAX)));
    tmo_hit     = (state_q == RUN) && (cfg_max_cycles != '0) &&
                  (run_cnt_inc == cfg_max_cycles);
    run_end     = (state_q == RUN) && !abort && (halted || tmo_hit);
    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = RST;
      end
      RST: begin
        if (abort)                        state_d = IDLE;
        else if (rst_cnt_q == RST_LAST)   state_d = RUN;
      end
      RUN: begin
        if (abort)        state_d = IDLE;
        else if (run_end) state_d = (run_idx == LAST_IDX) ? IDLE : RST;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, flags and registered outputs. Outputs are derived from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      mismatch   <= 1'b0;
      cycles     <= '0;
      run_idx    <= '0;
      rst_cnt_q  <= '0;
      run_cnt_q  <= '0;
      ref_q      <= '0;
    end else begin
      core_reset <= (state_d != RUN);
      busy       <= (state_d != IDLE);
      done       <= 1'b0;

      if ((state_q == RST) && (state_d == RST)) rst_cnt_q <= rst_cnt_q + 1'b1;
      else                                      rst_cnt_q <= '0;

      if ((state_q == RUN) && (state_d == RUN)) run_cnt_q <= run_cnt_inc;
      else                                      run_cnt_q <= '0;

      if ((state_q == IDLE) && (state_d == RST)) begin
        timeout  <= 1'b0;
        mismatch <= 1'b0;
        run_idx  <= '0;
      end

      if (run_end) begin
        cycles <= run_cnt_inc;
        // Halt wins a same-cycle tie, so only a pure budget hit is a timeout.
        if (!halted) timeout <= 1'b1;
        if (run_idx == '0)              ref_q    <= run_cnt_inc;
        else if (run_cnt_inc != ref_q)  mismatch <= 1'b1;
        if (run_idx == LAST_IDX) done    <= 1'b1;
        else                     run_idx <= run_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl (RST_CYCLES=2, NUM_RUNS=3,
// HALT_STABLE=4). A tiny core model counts RUN cycles and parks the PC on
// halt_pc from a chosen cycle per run.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam logic [31:0] HALT_ADDR = 32'h0000_3020;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] cfg_max_cycles;
  logic [31:0] halt_pc;
  logic [31:0] cpu_pc;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        mismatch;
  logic [31:0] cycles;
  logic [1:0]  run_idx;
  run_state_t  state_dbg;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RST_CYCLES  (2),
    .NUM_RUNS    (3),
    .HALT_STABLE (4),
    .PC_W        (32),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_max_cycles (cfg_max_cycles),
    .halt_pc        (halt_pc),
    .cpu_pc         (cpu_pc),
    .core_reset     (core_reset),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .mismatch       (mismatch),
    .cycles         (cycles),
    .run_idx        (run_idx),
    .state_dbg      (state_dbg)
  );

  // ---------------- core model ----------------
  // halt_at[r] = RUN cycle (1-based) at which run r reaches halt_pc; 0 = never.
  int          halt_at [3];
  int          core_cyc = 0;
  int          run_cyc;
  int          cur_halt;

  always @(posedge clk) begin
    if (core_reset) core_cyc <= 0;
    else            core_cyc <= core_cyc + 1;
  end

  always_comb begin
    run_cyc  = core_cyc + 1;
    cur_halt = (run_idx < 2'd3) ? halt_at[run_idx] : 0;
    if (!core_reset && (cur_halt != 0) && (run_cyc >= cur_halt))
      cpu_pc = HALT_ADDR;
    else
      cpu_pc = 32'h0000_1000 + 32'(run_cyc * 4);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count cycles with core_reset high, starting in the current cycle.
  task automatic measure_reset(output int rc);
    rc = 0;
    while (core_reset && rc < 20) begin
      rc++;
      tick();
    end
  endtask

  // Count RUN cycles; returns in the first cycle after the run ended.
  task automatic measure_run(output int rn);
    rn = 0;
    while (!core_reset && rn < 400) begin
      rn++;
      tick();
    end
  endtask

  task automatic run_all(input int first, input int e0, input int e1,
                         input int e2, input logic exp_mm, input logic exp_to);
    int rc;
    int rn;
    int exp_rn;
    for (int r = first; r < 3; r++) begin
      exp_rn = (r == 0) ? e0 : (r == 1) ? e1 : e2;
      measure_reset(rc);
      check_eq("rst_len", 64'(rc), 64'd2);
      check_eq("run_idx", 64'(run_idx), 64'(r));
      measure_run(rn);
      check_eq("run_len", 64'(rn), 64'(exp_rn));
      check_eq("cycles", 64'(cycles), 64'(exp_rn));
      check_eq("done_at_end", 64'(done), 64'(r == 2));
      check_eq("busy_at_end", 64'(busy), 64'(r != 2));
    end
    check_eq("mismatch", 64'(mismatch), 64'(exp_mm));
    check_eq("timeout", 64'(timeout), 64'(exp_to));
    tick();
    check_eq("done_single", 64'(done), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    int rn;
    reset          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_max_cycles = 32'd0;
    halt_pc        = HALT_ADDR;
    halt_at        = '{10, 10, 10};

    repeat (3) tick();
    check_eq("rst_core_reset", 64'(core_reset), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_cycles", 64'(cycles), 64'd0);
    check_eq("rst_run_idx", 64'(run_idx), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk) reset = 1'b1;
    tick();

    // Basic halt, three identical runs of 13 cycles.
    do_start();
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_core_reset", 64'(core_reset), 64'd1);
    check_eq("start_state", 64'(state_dbg), 64'(RST));
    run_all(0, 13, 13, 13, 1'b0, 1'b0);

    // Third run one cycle longer: mismatch flagged.
    halt_at = '{10, 10, 11};
    do_start();
    run_all(0, 13, 13, 14, 1'b1, 1'b0);

    // Budget of 50, PC never halts.
    halt_at        = '{0, 0, 0};
    cfg_max_cycles = 32'd50;
    do_start();
    check_eq("start_clears_mismatch", 64'(mismatch), 64'd0);
    run_all(0, 50, 50, 50, 1'b0, 1'b1);

    // Halt and budget in the same cycle: halt wins.
    halt_at        = '{10, 10, 10};
    cfg_max_cycles = 32'd13;
    do_start();
    check_eq("start_clears_timeout", 64'(timeout), 64'd0);
    run_all(0, 13, 13, 13, 1'b0, 1'b0);

    // Abort in RUN cycle 5.
    cfg_max_cycles = 32'd0;
    do_start();
    measure_reset(rc);
    check_eq("abort_rst_len", 64'(rc), 64'd2);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_state", 64'(state_dbg), 64'(IDLE));
    check_eq("abort_core_reset", 64'(core_reset), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_cycles", 64'(cycles), 64'd13);
    tick();
    check_eq("abort_done_later", 64'(done), 64'd0);
    do_start();
    run_all(0, 13, 13, 13, 1'b0, 1'b0);

    // start held high while busy.
    start = 1'b1;
    tick();
    measure_reset(rc);
    check_eq("held_rst_len", 64'(rc), 64'd2);
    measure_run(rn);
    check_eq("held_run_len", 64'(rn), 64'd13);
    check_eq("held_run_idx", 64'(run_idx), 64'd1);
    start = 1'b0;
    run_all(1, 13, 13, 13, 1'b0, 1'b0);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("sa_state", 64'(state_dbg), 64'(IDLE));
    check_eq("sa_busy", 64'(busy), 64'd0);
    check_eq("sa_core_reset", 64'(core_reset), 64'd1);

    // Async reset mid-RUN of run 1, after run 0 timed out.
    halt_at        = '{0, 0, 0};
    cfg_max_cycles = 32'd50;
    do_start();
    measure_reset(rc);
    measure_run(rn);
    check_eq("ar_run_len", 64'(rn), 64'd50);
    check_eq("ar_timeout_set", 64'(timeout), 64'd1);
    measure_reset(rc);
    repeat (3) tick();
    check_eq("ar_in_run", 64'(core_reset), 64'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_core_reset", 64'(core_reset), 64'd1);
    check_eq("ar_busy", 64'(busy), 64'd0);
    check_eq("ar_done", 64'(done), 64'd0);
    check_eq("ar_timeout", 64'(timeout), 64'd0);
    check_eq("ar_mismatch", 64'(mismatch), 64'd0);
    check_eq("ar_cycles", 64'(cycles), 64'd0);
    check_eq("ar_run_idx", 64'(run_idx), 64'd0);
    check_eq("ar_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk) reset = 1'b1;
    tick();
    check_eq("ar_idle_after", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
